pick15_turn_ctrl: RTL and testbench

Turn sequencer for the Pick-15 game datapath. Players alternately claim distinct numbers 1..9; the first player holding three numbers that sum to 15 wins.
- Arbitrates turns between the human input (hMove/enter_L) and the computer-strategy block (req/valid handshake).
- Owns the taken-number masks, validates every move, counts moves, and flags win, draw, illegal entry and strategy fault.
- Drives the display/strategy logic through its mask and status outputs.

---
 rtl/pick15_turn_ctrl_pkg.sv | 45 ++++
 rtl/pick15_turn_ctrl_if.sv | 28 ++
 rtl/pick15_turn_ctrl_press_detect.sv | 30 +++
 rtl/pick15_turn_ctrl.sv | 123 ++++++++++++
 tb/tb_pick15_turn_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pick15_turn_ctrl_pkg.sv
// Shared types, win-line table and move helpers for the Pick-15 turn sequencer.
// HUMAN_FIRST_EN selects the opening player (defined: human moves first).
package pick15_pkg;

   typedef enum logic [2:0] {
      COMP_REQ,
      EVAL_C,
      H_WAIT,
      EVAL_H,
      DONE,
      FAULT
   } state_t;

`ifdef HUMAN_FIRST_EN
   localparam state_t START_STATE = H_WAIT;
`else
   localparam state_t START_STATE = COMP_REQ;
`endif

   // Rows, columns and diagonals of the 3x3 magic square; bit i-1 = number i.
   localparam logic [8:0] WIN_LINES [8] = '{
      9'h111, 9'h0A1, 9'h10A, 9'h092,
      9'h062, 9'h08C, 9'h054, 9'h038
   };

   function automatic logic [8:0] moveBit(input logic [3:0] move);
      if (move >= 4'd1 && move <= 4'd9)
         return 9'd1 << (move - 4'd1);
      return 9'd0;
   endfunction

   function automatic logic lineWon(input logic [8:0] mask);
      logic won;
      won = 1'b0;
      for (int i = 0; i < 8; i++)
         if ((mask & WIN_LINES[i]) == WIN_LINES[i])
            won = 1'b1;
      return won;
   endfunction

   function automatic logic legal(input logic [3:0] move, input logic [8:0] taken);
      return (moveBit(move) != 9'd0) && ((moveBit(move) & taken) == 9'd0);
   endfunction

endpackage

// File: rtl/pick15_turn_ctrl_if.sv
// Game-side signal bundle: player inputs, strategy handshake, masks and status.
interface pick15_turn_ctrl_if;
   logic       newGame_L;
   logic       enter_L;
   logic [3:0] hMove;
   logic [3:0] cMove;
   logic       cValid;
   logic       cReq;
   logic [8:0] hMask;
   logic [8:0] cMask;
   logic [3:0] moveCount;
   logic       humanTurn;
   logic       win;
   logic       humanWin;
   logic       draw;
   logic       illegal;
   logic       fault;

   modport master (
      output newGame_L, enter_L, hMove, cMove, cValid,
      input  cReq, hMask, cMask, moveCount, humanTurn, win, humanWin, draw, illegal, fault
   );

   modport slave (
      input  newGame_L, enter_L, hMove, cMove, cValid,
      output cReq, hMask, cMask, moveCount, humanTurn, win, humanWin, draw, illegal, fault
   );
endinterface

// File: rtl/pick15_turn_ctrl_press_detect.sv
// Enter-button debounce: re-arms on release, fires one press after PRESS_MIN low cycles.
module press_detect #(
   parameter int PRESS_MIN = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enter_L,
   output logic press
);
   logic       armed;
   logic [3:0] cnt;

   assign press = armed && !enter_L && (cnt == 4'(PRESS_MIN - 1));

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         armed <= 1'b0;
         cnt   <= 4'd0;
      end else if (enter_L) begin
         armed <= 1'b1;
         cnt   <= 4'd0;
      end else if (armed) begin
         cnt <= cnt + 4'd1;
         // A held button must be released before the next press can arm.
         if (press)
            armed <= 1'b0;
      end
   end
endmodule

// File: rtl/pick15_turn_ctrl.sv
// Pick-15 turn sequencer: alternates human and strategy moves, tracks masks, win/draw/fault.
// HUMAN_FIRST_EN (see pick15_pkg) makes the human open the game.
//
// state    | meaning
// COMP_REQ | requesting a move from the strategy block
// EVAL_C   | checking computer mask for win/draw
// H_WAIT   | waiting for a debounced human press
// EVAL_H   | checking human mask for win/draw
// DONE     | game over, results held
// FAULT    | strategy returned an illegal move
module pick15_turn_ctrl
   import pick15_pkg::*;
#(
   parameter int PRESS_MIN = 2
) (
   input logic               clock,
   input logic               reset,
   pick15_turn_ctrl_if.slave bus
);
   state_t     state, state_nxt;
   logic [8:0] hMask, cMask, taken;
   logic [3:0] moveCount;
   logic       win, humanWin, draw, illegal;
   logic       press, restart, cLegal, hLegal;

   assign restart = !bus.newGame_L;
   assign taken   = hMask | cMask;
   assign cLegal  = legal(bus.cMove, taken);
   assign hLegal  = legal(bus.hMove, taken);

   press_detect #(.PRESS_MIN(PRESS_MIN)) u_press (
      .clock   (clock),
      .reset   (reset),
      .clear   (restart),
      .enter_L (bus.enter_L),
      .press   (press)
   );

   always_ff @(posedge clock) begin
      if (reset)
         state <= START_STATE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COMP_REQ: if (bus.cValid) state_nxt = cLegal ? EVAL_C : FAULT;
         EVAL_C:   state_nxt = (lineWon(cMask) || moveCount == 4'd9) ? DONE : H_WAIT;
         H_WAIT:   if (press && hLegal) state_nxt = EVAL_H;
         EVAL_H:   state_nxt = (lineWon(hMask) || moveCount == 4'd9) ? DONE : COMP_REQ;
         DONE:     state_nxt = DONE;
         FAULT:    state_nxt = FAULT;
         default:  state_nxt = START_STATE;
      endcase
      if (restart)
         state_nxt = START_STATE;
   end

   always_comb begin
      bus.cReq      = 1'b0;
      bus.humanTurn = 1'b0;
      bus.fault     = 1'b0;
      case (state)
         COMP_REQ: bus.cReq      = 1'b1;
         H_WAIT:   bus.humanTurn = 1'b1;
         FAULT:    bus.fault     = 1'b1;
         default:  ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset || restart) begin
         hMask     <= 9'd0;
         cMask     <= 9'd0;
         moveCount <= 4'd0;
         win       <= 1'b0;
         humanWin  <= 1'b0;
         draw      <= 1'b0;
         illegal   <= 1'b0;
      end else begin
         illegal <= 1'b0;
         case (state)
            COMP_REQ:
               if (bus.cValid && cLegal) begin
                  cMask     <= cMask | moveBit(bus.cMove);
                  moveCount <= moveCount + 4'd1;
               end
            EVAL_C:
               if (lineWon(cMask)) begin
                  win      <= 1'b1;
                  humanWin <= 1'b0;
               end else if (moveCount == 4'd9)
                  draw <= 1'b1;
            H_WAIT:
               if (press) begin
                  if (hLegal) begin
                     hMask     <= hMask | moveBit(bus.hMove);
                     moveCount <= moveCount + 4'd1;
                  end else
                     illegal <= 1'b1;
               end
            EVAL_H:
               // Win is tested first so a ninth-move line beats the draw.
               if (lineWon(hMask)) begin
                  win      <= 1'b1;
                  humanWin <= 1'b1;
               end else if (moveCount == 4'd9)
                  draw <= 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.hMask     = hMask;
   assign bus.cMask     = cMask;
   assign bus.moveCount = moveCount;
   assign bus.win       = win;
   assign bus.humanWin  = humanWin;
   assign bus.draw      = draw;
   assign bus.illegal   = illegal;
endmodule

// File: tb/tb_pick15_turn_ctrl.sv
// Directed bench for pick15_turn_ctrl (default build: computer moves first).
module tb_pick15_turn_ctrl;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   pick15_turn_ctrl_if bus();

   pick15_turn_ctrl #(.PRESS_MIN(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic comp_move(input logic [3:0] m);
      int n;
      n = 0;
      while (bus.cReq !== 1'b1 && n < 50) begin
         tick(1);
         n++;
      end
      check("creq_wait", 16'(bus.cReq), 16'd1);
      bus.cMove  = m;
      bus.cValid = 1'b1;
      tick(1);
      bus.cValid = 1'b0;
   endtask

   task automatic human_move(input logic [3:0] m);
      int n;
      n = 0;
      while (bus.humanTurn !== 1'b1 && n < 50) begin
         tick(1);
         n++;
      end
      check("hturn_wait", 16'(bus.humanTurn), 16'd1);
      bus.hMove   = m;
      bus.enter_L = 1'b0;
      tick(2);
      bus.enter_L = 1'b1;
      tick(1);
   endtask

   task automatic new_game();
      bus.newGame_L = 1'b0;
      tick(1);
      bus.newGame_L = 1'b1;
   endtask

   initial begin
      bus.newGame_L = 1'b1;
      bus.enter_L   = 1'b1;
      bus.hMove     = 4'd0;
      bus.cMove     = 4'd0;
      bus.cValid    = 1'b0;
      tick(2);
      check("rst_creq",  16'(bus.cReq), 16'd1);
      check("rst_hmask", 16'(bus.hMask), 16'h000);
      check("rst_cmask", 16'(bus.cMask), 16'h000);
      check("rst_count", 16'(bus.moveCount), 16'd0);
      check("rst_flags", 16'({bus.win, bus.humanWin, bus.draw, bus.illegal, bus.fault, bus.humanTurn}), 16'd0);
      reset = 1'b0;

      // Computer opens with 5
      bus.cMove  = 4'd5;
      bus.cValid = 1'b1;
      tick(1);
      bus.cValid = 1'b0;
      check("c5_cmask", 16'(bus.cMask), 16'h010);
      check("c5_count", 16'(bus.moveCount), 16'd1);
      check("c5_creq_low", 16'(bus.cReq), 16'd0);
      tick(1);
      check("c5_hturn", 16'(bus.humanTurn), 16'd1);

      // Human 4: two low cycles needed
      bus.hMove   = 4'd4;
      bus.enter_L = 1'b0;
      tick(1);
      check("h4_not_yet", 16'(bus.hMask), 16'h000);
      tick(1);
      bus.enter_L = 1'b1;
      check("h4_hmask", 16'(bus.hMask), 16'h008);
      check("h4_count", 16'(bus.moveCount), 16'd2);
      check("h4_evalh_creq", 16'(bus.cReq), 16'd0);
      tick(1);
      check("h4_creq_rise", 16'(bus.cReq), 16'd1);

      comp_move(4'd1);
      check("c1_cmask", 16'(bus.cMask), 16'h011);
      tick(1);

      // Illegal entries: taken 5, then 0
      bus.hMove   = 4'd5;
      bus.enter_L = 1'b0;
      tick(2);
      check("ill5_pulse", 16'(bus.illegal), 16'd1);
      check("ill5_hmask", 16'(bus.hMask), 16'h008);
      check("ill5_count", 16'(bus.moveCount), 16'd3);
      bus.enter_L = 1'b1;
      tick(1);
      check("ill5_one_cycle", 16'(bus.illegal), 16'd0);
      check("ill5_hturn", 16'(bus.humanTurn), 16'd1);
      bus.hMove   = 4'd0;
      bus.enter_L = 1'b0;
      tick(2);
      check("ill0_pulse", 16'(bus.illegal), 16'd1);
      check("ill0_cmask", 16'(bus.cMask), 16'h011);
      bus.enter_L = 1'b1;
      tick(1);
      check("ill0_one_cycle", 16'(bus.illegal), 16'd0);

      // Held button: one move only, even after turn returns to human
      bus.hMove   = 4'd3;
      bus.enter_L = 1'b0;
      tick(2);
      check("held_hmask", 16'(bus.hMask), 16'h00C);
      check("held_count", 16'(bus.moveCount), 16'd4);
      bus.hMove = 4'd7;
      tick(1);
      check("held_creq", 16'(bus.cReq), 16'd1);
      bus.cMove  = 4'd2;
      bus.cValid = 1'b1;
      tick(1);
      bus.cValid = 1'b0;
      tick(5);
      check("held_no_second", 16'(bus.hMask), 16'h00C);
      check("held_count2", 16'(bus.moveCount), 16'd5);
      check("held_hturn", 16'(bus.humanTurn), 16'd1);
      check("held_no_illegal", 16'(bus.illegal), 16'd0);
      bus.enter_L = 1'b1;
      tick(1);
      human_move(4'd6);
      check("h6_hmask", 16'(bus.hMask), 16'h02C);

      // Computer completes {1,5,9}
      comp_move(4'd9);
      check("c9_cmask", 16'(bus.cMask), 16'h113);
      check("c9_win_late", 16'(bus.win), 16'd0);
      tick(1);
      check("cwin_win", 16'(bus.win), 16'd1);
      check("cwin_hwin", 16'(bus.humanWin), 16'd0);
      check("cwin_draw", 16'(bus.draw), 16'd0);
      bus.cMove  = 4'd3;
      bus.cValid = 1'b1;
      tick(1);
      bus.cValid = 1'b0;
      tick(2);
      check("done_hold_win", 16'(bus.win), 16'd1);
      check("done_ignore_cvalid", 16'(bus.cMask), 16'h113);
      check("done_creq", 16'(bus.cReq), 16'd0);
      new_game();
      check("ng_cmask", 16'(bus.cMask), 16'h000);
      check("ng_hmask", 16'(bus.hMask), 16'h000);
      check("ng_count", 16'(bus.moveCount), 16'd0);
      check("ng_win", 16'(bus.win), 16'd0);
      check("ng_creq", 16'(bus.cReq), 16'd1);

      // Draw: C {2,6,9,3,8}, H {5,7,1,4}
      comp_move(4'd2);
      human_move(4'd5);
      comp_move(4'd6);
      human_move(4'd7);
      comp_move(4'd9);
      human_move(4'd1);
      comp_move(4'd3);
      human_move(4'd4);
      comp_move(4'd8);
      tick(1);
      check("draw_flag", 16'(bus.draw), 16'd1);
      check("draw_win", 16'(bus.win), 16'd0);
      check("draw_count", 16'(bus.moveCount), 16'd9);
      check("draw_cmask", 16'(bus.cMask), 16'h1A6);
      check("draw_hmask", 16'(bus.hMask), 16'h059);
      new_game();

      // Human completes {3,5,7}
      comp_move(4'd1);
      human_move(4'd5);
      comp_move(4'd2);
      human_move(4'd3);
      comp_move(4'd4);
      human_move(4'd7);
      check("hwin_win", 16'(bus.win), 16'd1);
      check("hwin_hwin", 16'(bus.humanWin), 16'd1);
      check("hwin_count", 16'(bus.moveCount), 16'd6);
      new_game();

      // Strategy fault
      comp_move(4'd12);
      check("fault_set", 16'(bus.fault), 16'd1);
      check("fault_creq", 16'(bus.cReq), 16'd0);
      check("fault_cmask", 16'(bus.cMask), 16'h000);
      tick(3);
      check("fault_hold", 16'(bus.fault), 16'd1);
      new_game();
      check("fault_ng_clear", 16'(bus.fault), 16'd0);
      check("fault_ng_creq", 16'(bus.cReq), 16'd1);
      comp_move(4'd12);
      check("fault_again", 16'(bus.fault), 16'd1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("fault_rst_clear", 16'(bus.fault), 16'd0);
      check("fault_rst_creq", 16'(bus.cReq), 16'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
